// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
// Ports:
//   clock      - sole clock, rising edge
//   reset_n    - synchronous active-low reset
//   uart_in    - [8] one-cycle write strobe, [7:0] byte to queue
//   tx         - registered serial line
//   busy       - frame in flight or bytes queued
//   fifo_count - bytes currently queued
//   overflow   - sticky: a strobed byte was dropped because the FIFO was full
//   tx_done    - one-cycle pulse after a frame's stop bit completes
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [8:0]                    uart_in,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          tx_done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   baud, baud_n;
  logic [2:0]      bit_cnt, bit_cnt_n;
  logic [7:0]      shift, shift_n;
  logic            tx_n, done_n;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_n;
  logic            push, drop, pop;
  logic            baud_wrap;

  // FIFO admission: a full FIFO drops the byte even if a pop frees a slot this cycle
  always_comb begin
    push = uart_in[8] && (fifo_count < CW'(FIFO_DEPTH));
    drop = uart_in[8] && (fifo_count == CW'(FIFO_DEPTH));
  end

  // Occupancy update from push/pop
  always_comb begin
    count_n = fifo_count;
    case ({push, pop})
      2'b10:   count_n = fifo_count + CW'(1);
      2'b01:   count_n = fifo_count - CW'(1);
      default: count_n = fifo_count;
    endcase
  end

  assign baud_wrap = (baud == BW'(CLKS_PER_BIT - 1));

  // Transmitter next-state; tx is computed one cycle ahead so it can be registered
  always_comb begin
    state_n   = state;
    baud_n    = baud_wrap ? '0 : baud + BW'(1);
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    tx_n      = tx;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          bit_cnt_n = '0;
          state_n   = START;
          tx_n      = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_n = DATA;
          baud_n  = '0;
          tx_n    = shift[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          shift_n = shift >> 1;
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            baud_n  = '0;
            tx_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + 3'd1;
            tx_n      = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_wrap) begin
          state_n = IDLE;
          baud_n  = '0;
          done_n  = 1'b1;
          tx_n    = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers do
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= uart_in[7:0];
  end

  // State, FIFO control and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud       <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      tx         <= tx_n;
      tx_done    <= done_n;
      fifo_count <= count_n;
      busy       <= (state_n != IDLE) || (count_n != '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule
